tff_counter: RTL

TFF_COUNTER -- requirements
Module: tff_counter

---
 rtl/tff_pkg.sv | 10 +
 rtl/tff_cell.sv | 31 +++
 rtl/tff_counter.sv | 71 +++++++
 3 files changed

// File: rtl/tff_pkg.sv
// Shared constants for the T-flip-flop counter: direction encoding and legal widths.
package tff_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/tff_cell.sv
// One counter bit: a T flip-flop with synchronous clear/load overrides
// and an asynchronous active-low reset.
module tff_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  input  logic sclr,
  input  logic sload,
  input  logic d,
  output logic q,
  output logic qbar
);

  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= 1'b0;
    end else if (sclr) begin
      r_q <= 1'b0;
    end else if (sload) begin
      r_q <= d;
    end else if (t) begin
      r_q <= ~r_q;
    end
  end

  assign q    = r_q;
  assign qbar = ~r_q;

endmodule

// File: rtl/tff_counter.sv
// Up/down counter built from a chain of T flip-flop cells, with wrap or
// saturate behaviour at the limits and a registered limit-event pulse.
module tff_counter
  import tff_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             ovf
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("tff_counter: WIDTH %0d outside legal range %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
  end

  // w_all1[i] / w_all0[i]: bits q[i-1:0] are all ones / all zeros.
  logic [WIDTH:0]   w_all1;
  logic [WIDTH:0]   w_all0;
  logic [WIDTH-1:0] w_t;
  logic             w_up;
  logic             w_hold;
  logic             w_cnt;
  logic             r_ovf;

  assign w_up      = (up_dn == DIR_UP);
  assign w_all1[0] = 1'b1;
  assign w_all0[0] = 1'b1;

  assign tc     = w_up ? w_all1[WIDTH] : w_all0[WIDTH];
  assign w_hold = (SATURATE != 0) && tc;
  assign w_cnt  = en && !w_hold;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign w_all1[gi+1] = w_all1[gi] & q[gi];
    assign w_all0[gi+1] = w_all0[gi] & ~q[gi];
    assign w_t[gi]      = w_cnt & (w_up ? w_all1[gi] : w_all0[gi]);

    tff_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .t     (w_t[gi]),
      .sclr  (clr),
      .sload (load),
      .d     (din[gi]),
      .q     (q[gi]),
      .qbar  (qbar[gi])
    );
  end

  // Pulses after any counting edge that sat at a limit, whether it wrapped or held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= en && tc && !clr && !load;
    end
  end

  assign ovf = r_ovf;

endmodule
